// File: rtl/alu_pkg.sv
// Opcode constants, sequencer state encoding and opcode validation shared by
// the ALU, the UART frontend and its testbench.
package alu_pkg;

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_NOR = 6'b100111;
  localparam logic [5:0] OP_SRA = 6'b000011;
  localparam logic [5:0] OP_SRL = 6'b000010;

  typedef enum logic [2:0] {
    WAIT_A,
    WAIT_B,
    WAIT_OP,
    EXEC,
    SEND
  } frontend_state_t;

  // A byte is a legal opcode only if everything above the opcode field is zero
  // and the field holds one of the supported operations.
  function automatic logic is_valid_op(input logic [31:0] data, input int unsigned op_bits);
    logic [31:0] low;
    low = data & ((32'd1 << op_bits) - 32'd1);
    if ((data >> op_bits) != '0) return 1'b0;
    case (low)
      32'(OP_ADD), 32'(OP_SUB), 32'(OP_AND), 32'(OP_OR),
      32'(OP_XOR), 32'(OP_NOR), 32'(OP_SRA), 32'(OP_SRL): return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_uart_frontend.sv
// Collects A, B and opcode bytes from the UART receiver, holds them as ALU
// inputs, then forwards the ALU result to the transmitter via start/busy.
module alu_uart_frontend
  import alu_pkg::*;
#(
  parameter int unsigned N_BITS  = 8,
  parameter int unsigned OP_BITS = 6
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic [N_BITS-1:0]  i_rx_data,
  input  logic               i_rx_done,
  input  logic [N_BITS-1:0]  i_alu_result,
  output logic [N_BITS-1:0]  o_alu_a,
  output logic [N_BITS-1:0]  o_alu_b,
  output logic [OP_BITS-1:0] o_alu_op,
  output logic [N_BITS-1:0]  o_tx_data,
  output logic               o_tx_start,
  input  logic               i_tx_busy,
  output logic               o_op_err,
  output logic               o_overrun
);

  frontend_state_t state_q, state_d;
  logic            op_ok;

  assign op_ok = is_valid_op(32'(i_rx_data), OP_BITS);

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) state_q <= WAIT_A;
    else         state_q <= state_d;
  end

  // Start pulse is combinational from SEND so a busy transmitter is seen in
  // the very cycle the request would go out.
  always_comb begin
    state_d    = state_q;
    o_tx_start = 1'b0;
    case (state_q)
      WAIT_A:  if (i_rx_done) state_d = WAIT_B;
      WAIT_B:  if (i_rx_done) state_d = WAIT_OP;
      WAIT_OP: if (i_rx_done && op_ok) state_d = EXEC;
      EXEC:    state_d = SEND;
      SEND: begin
        if (!i_tx_busy) begin
          o_tx_start = 1'b1;
          state_d    = WAIT_A;
        end
      end
      default: state_d = WAIT_A;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      o_alu_a   <= '0;
      o_alu_b   <= '0;
      o_alu_op  <= '0;
      o_tx_data <= '0;
      o_op_err  <= 1'b0;
      o_overrun <= 1'b0;
    end else begin
      if (i_rx_done) begin
        case (state_q)
          WAIT_A:  o_alu_a <= i_rx_data;
          WAIT_B:  o_alu_b <= i_rx_data;
          WAIT_OP: begin
            if (op_ok) o_alu_op <= i_rx_data[OP_BITS-1:0];
            else       o_op_err <= 1'b1;
          end
          EXEC, SEND: o_overrun <= 1'b1;
          default: ;
        endcase
      end
      if (state_q == EXEC) o_tx_data <= i_alu_result;
    end
  end

endmodule
